// File: rtl/enigma_tx_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enigma_tx_arbiter_if : requester handshakes and uart_top transmit port
// Rev 1.0
// ---------------------------------------------------------------------------
interface enigma_tx_arbiter_if;
  logic [7:0]  i_req0_data;
  logic        i_req0_valid;
  logic        i_req0_last;
  logic        o_req0_ready;
  logic [7:0]  i_req1_data;
  logic        i_req1_valid;
  logic        i_req1_last;
  logic        o_req1_ready;
  logic [79:0] o_tx_data;
  logic        o_tx_stb;
  logic        i_tx_busy;
  logic        o_owner;
  logic [15:0] o_frames_sent;

  modport master (
    output i_req0_data, i_req0_valid, i_req0_last,
    output i_req1_data, i_req1_valid, i_req1_last,
    output i_tx_busy,
    input  o_req0_ready, o_req1_ready,
    input  o_tx_data, o_tx_stb, o_owner, o_frames_sent
  );

  modport slave (
    input  i_req0_data, i_req0_valid, i_req0_last,
    input  i_req1_data, i_req1_valid, i_req1_last,
    input  i_tx_busy,
    output o_req0_ready, o_req1_ready,
    output o_tx_data, o_tx_stb, o_owner, o_frames_sent
  );
endinterface

`default_nettype wire

// File: rtl/enigma_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enigma_tx_arbiter : round-robin frame packer sharing the 80-bit UART port
// Optional: ENIGMA_TXARB_TAG_EN puts an owner/count header in slot 0.
// Rev 1.0
// ---------------------------------------------------------------------------
module enigma_tx_arbiter #(
  parameter logic [7:0]  PAD_BYTE     = 8'h20,
  parameter int unsigned FLUSH_CYCLES = 1000
) (
  input wire logic         clk,
  input wire logic         rst_n,
  enigma_tx_arbiter_if.slave bus
);

`ifdef ENIGMA_TXARB_TAG_EN
  localparam logic [3:0] FULL_CNT = 4'd9;
`else
  localparam logic [3:0] FULL_CNT = 4'd10;
`endif
  localparam logic [15:0] FLUSH_LIM = 16'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    SEND      = 2'd2,
    WAIT_BUSY = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        owner, last_grant;
  logic [3:0]  cnt;
  logic [15:0] timer;
  logic [7:0]  slots [10];
  logic        rdy0, rdy1;
  logic [79:0] tx_data;
  logic        tx_stb;
  logic [15:0] frames;
  logic [2:0]  wait_cnt;
  logic        busy_seen;

  logic        grant, grant_id, accept, release_owner, launch;
  logic        owner_n;
  logic [7:0]  acc_data;
  logic        acc_last;
  logic [3:0]  cnt_inc, wr_slot;
  logic [15:0] timer_inc;
  logic [79:0] frame;

  assign acc_data  = owner ? bus.i_req1_data : bus.i_req0_data;
  assign acc_last  = owner ? bus.i_req1_last : bus.i_req0_last;
  assign cnt_inc   = cnt + 4'd1;
  assign timer_inc = timer + 16'd1;
`ifdef ENIGMA_TXARB_TAG_EN
  assign wr_slot   = cnt + 4'd1;
`else
  assign wr_slot   = cnt;
`endif

  always_comb begin
    frame = '0;
    for (int i = 0; i < 10; i++) begin
      frame[8*(9-i) +: 8] = slots[i];
    end
`ifdef ENIGMA_TXARB_TAG_EN
    frame[79:72] = {owner, 3'b000, cnt};
`endif
  end

  always_comb begin
    state_n       = state;
    grant         = 1'b0;
    grant_id      = owner;
    accept        = 1'b0;
    release_owner = 1'b0;
    launch        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req0_valid || bus.i_req1_valid) begin
          grant    = 1'b1;
          grant_id = (bus.i_req0_valid && bus.i_req1_valid) ? ~last_grant
                                                            : bus.i_req1_valid;
          state_n  = FILL;
        end
      end
      FILL: begin
        accept = owner ? (rdy1 && bus.i_req1_valid) : (rdy0 && bus.i_req0_valid);
        if (accept) begin
          if (cnt_inc == FULL_CNT || acc_last) begin
            state_n = SEND;
          end
        end else if (timer_inc == FLUSH_LIM) begin
          // An empty grant gives up its turn without launching anything.
          if (cnt != 4'd0) begin
            state_n = SEND;
          end else begin
            state_n       = IDLE;
            release_owner = 1'b1;
          end
        end
      end
      SEND: begin
        if (!bus.i_tx_busy) begin
          launch  = 1'b1;
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A UART that never raises busy would otherwise stall us forever.
        if (!bus.i_tx_busy && (busy_seen || wait_cnt == 3'd3)) begin
          state_n       = IDLE;
          release_owner = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign owner_n = grant ? grant_id : owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      timer      <= '0;
      rdy0       <= 1'b0;
      rdy1       <= 1'b0;
      tx_data    <= '0;
      tx_stb     <= 1'b0;
      frames     <= '0;
      wait_cnt   <= '0;
      busy_seen  <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        slots[i] <= '0;
      end
    end else begin
      rdy0   <= (state_n == FILL) && !owner_n;
      rdy1   <= (state_n == FILL) && owner_n;
      tx_stb <= launch;
      owner  <= owner_n;
      if (grant) begin
        cnt   <= '0;
        timer <= '0;
        for (int i = 0; i < 10; i++) begin
          slots[i] <= PAD_BYTE;
        end
      end
      if (accept) begin
        slots[wr_slot] <= acc_data;
        cnt            <= cnt_inc;
        timer          <= '0;
      end else if (state == FILL) begin
        timer <= timer_inc;
      end
      if (release_owner) begin
        last_grant <= owner;
      end
      if (launch) begin
        tx_data   <= frame;
        frames    <= frames + 16'd1;
        wait_cnt  <= '0;
        busy_seen <= 1'b0;
      end else if (state == WAIT_BUSY) begin
        if (bus.i_tx_busy) begin
          busy_seen <= 1'b1;
        end
        if (wait_cnt != 3'd7) begin
          wait_cnt <= wait_cnt + 3'd1;
        end
      end
    end
  end

  assign bus.o_req0_ready  = rdy0;
  assign bus.o_req1_ready  = rdy1;
  assign bus.o_tx_data     = tx_data;
  assign bus.o_tx_stb      = tx_stb;
  assign bus.o_owner       = owner;
  assign bus.o_frames_sent = frames;

endmodule

`default_nettype wire

// File: tb/tb_enigma_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_enigma_tx_arbiter : directed self-checking bench for enigma_tx_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_enigma_tx_arbiter;

`ifdef ENIGMA_TXARB_TAG_EN
  localparam int FULL = 9;
`else
  localparam int FULL = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   stb_cnt;
  bit   r1_seen;
  bit   any_rdy;

  enigma_tx_arbiter_if bus ();

  enigma_tx_arbiter #(
    .PAD_BYTE     (8'h20),
    .FLUSH_CYCLES (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_tx_stb) stb_cnt++;
    if (bus.o_req1_ready) r1_seen = 1'b1;
    if (bus.o_req0_ready || bus.o_req1_ready) any_rdy = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit who, input bit v, input logic [7:0] d, input bit l);
    if (who) begin
      bus.i_req1_valid = v; bus.i_req1_data = d; bus.i_req1_last = l;
    end else begin
      bus.i_req0_valid = v; bus.i_req0_data = d; bus.i_req0_last = l;
    end
  endtask

  function automatic logic rdy(input bit who);
    return who ? bus.o_req1_ready : bus.o_req0_ready;
  endfunction

  // Holds valid until ready is seen, then returns just after the accept edge.
  task automatic push(input bit who, input logic [7:0] d, input bit l);
    int n;
    n = 0;
    drive(who, 1'b1, d, l);
    while (!rdy(who) && n < 2000) begin
      tick();
      n++;
    end
    check("push_ready", rdy(who), 1);
    tick();
    drive(who, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int s0;
    n_checks = 0; n_pass = 0; stb_cnt = 0;
    r1_seen = 1'b0; any_rdy = 1'b0;
    rst_n = 1'b0;
    bus.i_tx_busy = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    check("rst_rdy0",   bus.o_req0_ready, 0);
    check("rst_rdy1",   bus.o_req1_ready, 0);
    check("rst_stb",    bus.o_tx_stb, 0);
    check("rst_data",   bus.o_tx_data, 80'h0);
    check("rst_owner",  bus.o_owner, 0);
    check("rst_frames", bus.o_frames_sent, 0);
    rst_n = 1'b1;
    tick();

    // Full frame from requester 0
    r1_seen = 1'b0;
    for (int i = 0; i < FULL; i++) push(0, 8'h41 + 8'(i), 1'b0);
    check("full_rdy_drop", bus.o_req0_ready, 0);
    tick();
    check("full_stb", bus.o_tx_stb, 1);
`ifdef ENIGMA_TXARB_TAG_EN
    check("full_data", bus.o_tx_data, 80'h0941_4243_4445_4647_4849);
`else
    check("full_data", bus.o_tx_data, 80'h4142_4344_4546_4748_494A);
`endif
    check("full_frames", bus.o_frames_sent, 1);
    tick();
    check("stb_one_cycle", bus.o_tx_stb, 0);
    repeat (8) tick();
    check("full_stb_cnt", stb_cnt, 1);
    check("full_r1_rdy", r1_seen, 0);

    // Short message from requester 1
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b0);
    push(1, 8'h63, 1'b1);
    check("short_rdy_drop", bus.o_req1_ready, 0);
    tick();
    check("short_stb", bus.o_tx_stb, 1);
`ifdef ENIGMA_TXARB_TAG_EN
    check("short_data", bus.o_tx_data, 80'h8361_6263_2020_2020_2020);
`else
    check("short_data", bus.o_tx_data, 80'h6162_6320_2020_2020_2020);
`endif
    check("short_owner", bus.o_owner, 1);
    check("short_frames", bus.o_frames_sent, 2);
    repeat (8) tick();

    // Simultaneous requests: 0 first after reset, then 1, then 0 again
    do_reset();
    drive(1, 1'b1, 8'h31, 1'b1);
    push(0, 8'h30, 1'b1);
    check("sim1_owner", bus.o_owner, 0);
    check("sim1_frames", bus.o_frames_sent, 0);
    tick();
`ifdef ENIGMA_TXARB_TAG_EN
    check("sim1_data", bus.o_tx_data, 80'h0130_2020_2020_2020_2020);
`else
    check("sim1_data", bus.o_tx_data, 80'h3020_2020_2020_2020_2020);
`endif
    push(1, 8'h31, 1'b1);
    tick();
    check("sim2_owner", bus.o_owner, 1);
    check("sim2_frames", bus.o_frames_sent, 2);
`ifdef ENIGMA_TXARB_TAG_EN
    check("sim2_data", bus.o_tx_data, 80'h8131_2020_2020_2020_2020);
`else
    check("sim2_data", bus.o_tx_data, 80'h3120_2020_2020_2020_2020);
`endif
    repeat (8) tick();
    drive(1, 1'b1, 8'h34, 1'b1);
    push(0, 8'h32, 1'b1);
    check("sim3_owner", bus.o_owner, 0);
    check("sim3_frames", bus.o_frames_sent, 2);
    tick();
    push(1, 8'h34, 1'b1);
    tick();
    check("sim4_frames", bus.o_frames_sent, 4);
    repeat (8) tick();

    // Timeout flush of a partial frame
    push(0, 8'h55, 1'b0);
    push(0, 8'hAA, 1'b0);
    n = 0;
    while (!bus.o_tx_stb && n < 1100) begin
      tick();
      n++;
    end
    check("flush_latency", n, 1001);
`ifdef ENIGMA_TXARB_TAG_EN
    check("flush_data", bus.o_tx_data, 80'h0255_AA20_2020_2020_2020);
`else
    check("flush_data", bus.o_tx_data, 80'h55AA_2020_2020_2020_2020);
`endif
    repeat (8) tick();

    // Empty grant times out silently
    s0 = stb_cnt;
    drive(0, 1'b1, 8'h00, 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    check("empty_grant_rdy", bus.o_req0_ready, 1);
    repeat (1010) tick();
    check("empty_no_stb", stb_cnt, s0);
    check("empty_released", bus.o_req0_ready, 0);

    // Busy held high with a complete frame waiting
    bus.i_tx_busy = 1'b1;
    for (int i = 0; i < FULL; i++) push(1, 8'h70 + 8'(i), 1'b0);
    drive(0, 1'b1, 8'h11, 1'b1);
    s0 = stb_cnt;
    any_rdy = 1'b0;
    repeat (500) tick();
    check("busy_no_stb", stb_cnt, s0);
    check("busy_no_rdy", any_rdy, 0);
    bus.i_tx_busy = 1'b0;
    tick();
    check("busy_stb", bus.o_tx_stb, 1);
`ifdef ENIGMA_TXARB_TAG_EN
    check("busy_data", bus.o_tx_data, 80'h8970_7172_7374_7576_7778);
`else
    check("busy_data", bus.o_tx_data, 80'h7071_7273_7475_7677_7879);
`endif
    bus.i_tx_busy = 1'b1;
    repeat (10) tick();
    check("wait_busy_no_rdy", any_rdy, 0);
    bus.i_tx_busy = 1'b0;
    push(0, 8'h11, 1'b1);
    tick();
`ifdef ENIGMA_TXARB_TAG_EN
    check("after_busy_data", bus.o_tx_data, 80'h0111_2020_2020_2020_2020);
`else
    check("after_busy_data", bus.o_tx_data, 80'h1120_2020_2020_2020_2020);
`endif
    repeat (8) tick();
    check("busy_stb_cnt", stb_cnt, s0 + 2);

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) push(1, 8'h01 + 8'(i), 1'b0);
    s0 = stb_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_rdy1",   bus.o_req1_ready, 0);
    check("midrst_data",   bus.o_tx_data, 80'h0);
    check("midrst_owner",  bus.o_owner, 0);
    check("midrst_frames", bus.o_frames_sent, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst_no_stb", stb_cnt, s0);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    tick();
`ifdef ENIGMA_TXARB_TAG_EN
    check("post_rst_data", bus.o_tx_data, 80'h83A1_A2A3_2020_2020_2020);
`else
    check("post_rst_data", bus.o_tx_data, 80'hA1A2_A320_2020_2020_2020);
`endif
    check("post_rst_frames", bus.o_frames_sent, 1);
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enigma_tx_arbiter.md
# enigma_tx_arbiter

Shares the single 80-bit `uart_top` transmit port between two byte-stream requesters: requester 0 is the encryptor ciphertext output, requester 1 is the status/echo path. Grants one requester a whole frame at a time, round-robin. Packs its bytes MSB-first into a 10-byte frame, pads unused slots, and launches the frame with a one-cycle strobe once the UART is idle. Sits between the Enigma core and `uart_top`.

## Interface
- `PAD_BYTE`, 8'h20: fill value for unused frame slots.
- `FLUSH_CYCLES`, 1000: idle cycles in FILL before a partial frame is flushed; legal range 2..65535.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req0_data` in 8: requester 0 byte.
- `i_req0_valid` in 1: requester 0 byte valid.
- `i_req0_last` in 1: byte ends requester 0 message.
- `o_req0_ready` out 1: requester 0 byte accepted when valid&ready.
- `i_req1_data`, `i_req1_valid`, `i_req1_last`, `o_req1_ready`: same as requester 0, for requester 1.
- `o_tx_data` out 80: frame to `uart_top` `i_tx_data`; byte [79:72] is sent first.
- `o_tx_stb` out 1: one-cycle launch strobe to `uart_top` `i_tx_stb`.
- `i_tx_busy` in 1: `uart_top` `o_tx_busy`.
- `o_owner` out 1: requester currently granted.
- `o_frames_sent` out 16: count of launched frames; wraps at 16'hFFFF→0.

## Operation
- States: IDLE, FILL, SEND, WAIT_BUSY.
- **IDLE**
  - If one requester has valid high, grant it.
  - If both have valid high, grant the requester not granted last. After reset, requester 0 wins.
  - On grant: clear the buffer to PAD_BYTE, count=0, timer=0, go to FILL.
- **FILL**
  - The granted requester's ready is high while count<10. The other requester's ready is 0.
  - Each accepted byte is written to slot `count`: slot 0 is [79:72], slot 9 is [7:0]. Then count increments and timer clears.
  - A cycle with no accept increments timer.
- **FILL exits**
  - Go to SEND when count reaches 10.
  - Go to SEND on an accepted byte with last=1.
  - Go to SEND when timer==FLUSH_CYCLES and count>0.
  - When timer==FLUSH_CYCLES and count==0: release the grant, record the owner as last-granted, go to IDLE with no strobe.
- **SEND**
  - When i_tx_busy==0: o_tx_data←buffer, o_tx_stb=1 for one cycle, o_frames_sent increments, go to WAIT_BUSY.
  - While i_tx_busy==1: hold in SEND.
- **WAIT_BUSY**
  - Wait for i_tx_busy high, then low, then go to IDLE and record the owner as last-granted.
  - If busy is not seen high within 4 cycles of the strobe, treat the frame as done and go to IDLE.
- A requester's last only ends its own frame. The next grant still follows round-robin.

## Timing
- Reset values:
  - State IDLE, all ready outputs 0, o_tx_stb 0, o_tx_data 80'h0, o_owner 0, o_frames_sent 0.
  - The buffer, count and timer are cleared.
  - The last-granted record is set to 1, so requester 0 wins the first arbitration.
- Reset asserted mid-frame discards the partial frame. No strobe is issued.
- All outputs are registered.
- Grant edge k (IDLE→FILL): o_owner updates and ready goes high from edge k onward.
- Completing accept at edge k (full or last): SEND from k. With busy low at edge k+1, o_tx_stb is high for cycle k+1..k+2, so strobe-to-accept latency is 1 cycle.
- Timeout flush: o_tx_stb rises FLUSH_CYCLES+1 edges after the last accept.
- o_tx_data is stable from the strobe until the next strobe.
- Ready drops in the same edge that makes count=10 or accepts last. No byte is accepted in SEND or WAIT_BUSY.

## Configuration
- `ENIGMA_TXARB_TAG_EN` defined:
  - Slot 0 of every frame is a header `{o_owner, 3'b000, payload_count[3:0]}`.
  - Payload occupies slots 1..9, so count saturates at 9 payload bytes and a frame is full at 9.
- Undefined: no header; 10 payload bytes per frame.

## Test plan
- **Full frame:** requester 0 sends bytes 0x41..0x4A back-to-back, busy low → one strobe with o_tx_data=80'h4142_4344_4546_4748_494A, o_frames_sent=1, o_req1_ready stays 0.
- **Short message:** requester 1 sends 0x61,0x62,0x63 with last on 0x63 → strobe with 80'h6162_6320_2020_2020_2020 one cycle after the 0x63 accept.
- **Simultaneous request:** both requesters valid after reset → requester 0 frame first, then requester 1; a third request from both goes to requester 0 again.
- **Timeout flush:** requester 0 sends 0x55,0xAA then idles, FLUSH_CYCLES=1000 → padded frame 80'h55AA_2020_2020_2020_2020 strobed 1001 edges after the 0xAA accept. A grant with zero bytes returns to IDLE with no strobe.
- **Busy held:** full frame ready while busy held high 500 cycles → no strobe and all readies 0 until the first busy-low cycle, then exactly one strobe.
- **Reset and tag mode:** rst_n pulsed low after 4 bytes → outputs return to reset values immediately, no strobe. With `ENIGMA_TXARB_TAG_EN` defined, requester 1 sending 3 bytes yields slot 0 = 8'h83.
